// File: rtl/lc3b_mem_sequencer.sv
// lc3b_mem_sequencer: memory-access sequencer between the CPU control FSM
// and the memory port. One word/byte read or write per request, byte-lane
// steering, and a bounded wait for mem_resp.
// Optional feature: define MEMSEQ_ALIGN_CHECK_EN to reject misaligned word
// accesses (done+err without touching memory).
module lc3b_mem_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  req_write_i,
  input  logic                  req_byte_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  output logic                  req_ready_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic [ADDR_W-1:0]     mem_address_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W/8-1:0]   mem_byte_enable_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  input  logic                  mem_resp_i
);

  localparam int NBYTES = DATA_W / 8;
  localparam int LB     = $clog2(NBYTES);
  localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] TMO_LAST = TMO_EN ? CW'(TIMEOUT - 1) : {CW{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic                byte_q, byte_d;
  logic [LB-1:0]       lane_q, lane_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NBYTES-1:0]   be_q, be_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   rd_shift_s;
  logic [LB-1:0]       req_lane_s;

  assign req_lane_s = req_addr_i[LB-1:0];
  // Selected byte lane of the read data moved down to bits [7:0].
  assign rd_shift_s = mem_rdata_i >> {lane_q, 3'b000};

  // State and captured-request registers; reset drops all strobes at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      lane_q  <= {LB{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      be_q    <= {NBYTES{1'b1}};
      rdata_q <= {DATA_W{1'b0}};
      err_q   <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      byte_q  <= byte_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: request capture, response/timeout handling, lane steering.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    byte_d  = byte_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          write_d = req_write_i;
          byte_d  = req_byte_i;
          lane_d  = req_lane_s;
          addr_d  = {req_addr_i[ADDR_W-1:LB], {LB{1'b0}}};
          cnt_d   = {CW{1'b0}};
          err_d   = 1'b0;
          if (req_byte_i) begin
            wdata_d = {NBYTES{req_wdata_i[7:0]}};
            if (req_write_i) begin
              be_d = {{(NBYTES-1){1'b0}}, 1'b1} << req_lane_s;
            end else begin
              be_d = {NBYTES{1'b1}};
            end
          end else begin
            wdata_d = req_wdata_i;
            be_d    = {NBYTES{1'b1}};
          end
`ifdef MEMSEQ_ALIGN_CHECK_EN
          // A misaligned word access completes with an error, memory untouched.
          if (!req_byte_i && (req_lane_s != {LB{1'b0}})) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_ACCESS;
          end
`else
          state_d = S_ACCESS;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (mem_resp_i) begin
          // A response on the timeout cycle still wins.
          if (!write_q) begin
            if (byte_q) begin
              rdata_d = {{(DATA_W-8){1'b0}}, rd_shift_s[7:0]};
            end else begin
              rdata_d = mem_rdata_i;
            end
          end else begin
            rdata_d = rdata_q;
          end
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          if (cnt_q != {CW{1'b1}}) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready_o       = (state_q == S_IDLE);
  assign done_o            = (state_q == S_DONE);
  assign err_o             = (state_q == S_DONE) && err_q;
  assign rdata_o           = rdata_q;
  assign mem_address_o     = addr_q;
  assign mem_read_o        = (state_q == S_ACCESS) && !write_q;
  assign mem_write_o       = (state_q == S_ACCESS) && write_q;
  assign mem_wdata_o       = wdata_q;
  assign mem_byte_enable_o = be_q;

endmodule

// File: tb/tb_lc3b_mem_sequencer.sv
// Directed testbench for lc3b_mem_sequencer (DATA_W=16, TIMEOUT=4).
module tb_lc3b_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0, req_write_i = 1'b0, req_byte_i = 1'b0;
  logic [15:0] req_addr_i = 16'h0000, req_wdata_i = 16'h0000;
  logic        req_ready_o, done_o, err_o, mem_read_o, mem_write_o;
  logic [15:0] rdata_o, mem_address_o, mem_wdata_o;
  logic [1:0]  mem_byte_enable_o;
  logic [15:0] mem_rdata_i = 16'h0000;
  logic        mem_resp_i = 1'b0;

  int tests_run = 0;
  int fails = 0;

  lc3b_mem_sequencer #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .req_write_i(req_write_i), .req_byte_i(req_byte_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_ready_o(req_ready_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .mem_address_o(mem_address_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_wdata_o(mem_wdata_o), .mem_byte_enable_o(mem_byte_enable_o),
    .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns in the first ACCESS cycle.
  task automatic issue(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
    req_i = 1'b1; req_write_i = w; req_byte_i = b; req_addr_i = a; req_wdata_i = d;
    tick();
    req_i = 1'b0;
  endtask

  // Respond in the current ACCESS cycle; returns in the DONE cycle.
  task automatic respond(input logic [15:0] d);
    mem_resp_i = 1'b1; mem_rdata_i = d;
    tick();
    mem_resp_i = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests_run++; if (req_ready_o !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", req_ready_o); end
    tests_run++; if ({done_o, err_o, mem_read_o, mem_write_o} !== 4'b0000) begin fails++; $display("FAIL rst_flags: got %b want 0000", {done_o, err_o, mem_read_o, mem_write_o}); end
    tests_run++; if ({rdata_o, mem_address_o, mem_wdata_o} !== 48'h0) begin fails++; $display("FAIL rst_data: got %h want 0", {rdata_o, mem_address_o, mem_wdata_o}); end
    tests_run++; if (mem_byte_enable_o !== 2'b11) begin fails++; $display("FAIL rst_be: got %b want 11", mem_byte_enable_o); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_word_read();
    issue(1'b0, 1'b0, 16'h1234, 16'h0000);
    tests_run++; if ({mem_read_o, mem_write_o, req_ready_o} !== 3'b100) begin fails++; $display("FAIL wr_strobe: got %b want 100", {mem_read_o, mem_write_o, req_ready_o}); end
    tests_run++; if (mem_address_o !== 16'h1234) begin fails++; $display("FAIL wr_addr: got %h want 1234", mem_address_o); end
    tests_run++; if (mem_byte_enable_o !== 2'b11) begin fails++; $display("FAIL wr_be: got %b want 11", mem_byte_enable_o); end
    tick();
    tick();
    tests_run++; if ({mem_read_o, done_o} !== 2'b10) begin fails++; $display("FAIL wr_hold: got %b want 10", {mem_read_o, done_o}); end
    respond(16'hBEEF);
    tests_run++; if ({done_o, err_o, mem_read_o} !== 3'b100) begin fails++; $display("FAIL wr_done: got %b want 100", {done_o, err_o, mem_read_o}); end
    tests_run++; if (rdata_o !== 16'hBEEF) begin fails++; $display("FAIL wr_rdata: got %h want beef", rdata_o); end
    tick();
    tests_run++; if ({done_o, req_ready_o} !== 2'b01 || rdata_o !== 16'hBEEF) begin fails++; $display("FAIL wr_idle: got %b %h want 01 beef", {done_o, req_ready_o}, rdata_o); end
  endtask

  task automatic test_resp_ignored();
    mem_resp_i = 1'b1; mem_rdata_i = 16'h5555;
    tick();
    tick();
    mem_resp_i = 1'b0;
    tests_run++; if (done_o !== 1'b0 || rdata_o !== 16'hBEEF) begin fails++; $display("FAIL idle_resp: got %b %h want 0 beef", done_o, rdata_o); end
  endtask

  task automatic test_byte_write();
    issue(1'b1, 1'b1, 16'h2001, 16'h00A5);
    tests_run++; if (mem_wdata_o !== 16'hA5A5) begin fails++; $display("FAIL bw_wdata: got %h want a5a5", mem_wdata_o); end
    tests_run++; if (mem_byte_enable_o !== 2'b10) begin fails++; $display("FAIL bw_be: got %b want 10", mem_byte_enable_o); end
    tests_run++; if (mem_address_o !== 16'h2000) begin fails++; $display("FAIL bw_addr: got %h want 2000", mem_address_o); end
    tick();
    tests_run++; if ({mem_write_o, mem_read_o} !== 2'b10 || mem_wdata_o !== 16'hA5A5) begin fails++; $display("FAIL bw_hold: got %b %h want 10 a5a5", {mem_write_o, mem_read_o}, mem_wdata_o); end
    respond(16'hFFFF);
    tests_run++; if ({done_o, err_o, mem_write_o} !== 3'b100 || rdata_o !== 16'hBEEF) begin fails++; $display("FAIL bw_done: got %b %h want 100 beef", {done_o, err_o, mem_write_o}, rdata_o); end
    tick();
    issue(1'b1, 1'b1, 16'h2000, 16'h1C3C);
    tests_run++; if (mem_byte_enable_o !== 2'b01 || mem_wdata_o !== 16'h3C3C) begin fails++; $display("FAIL bw_lane0: got %b %h want 01 3c3c", mem_byte_enable_o, mem_wdata_o); end
    respond(16'h0000);
    tick();
  endtask

  task automatic test_byte_read();
    issue(1'b0, 1'b1, 16'h3003, 16'h0000);
    tests_run++; if (mem_read_o !== 1'b1 || mem_address_o !== 16'h3002 || mem_byte_enable_o !== 2'b11) begin fails++; $display("FAIL br_req: got %b %h %b want 1 3002 11", mem_read_o, mem_address_o, mem_byte_enable_o); end
    respond(16'h1122);
    tests_run++; if (rdata_o !== 16'h0011) begin fails++; $display("FAIL br_hi: got %h want 0011", rdata_o); end
    tick();
    issue(1'b0, 1'b1, 16'h3002, 16'h0000);
    respond(16'h1122);
    tests_run++; if (rdata_o !== 16'h0022) begin fails++; $display("FAIL br_lo: got %h want 0022", rdata_o); end
    tick();
  endtask

  task automatic test_word_write_min_latency();
    issue(1'b1, 1'b0, 16'h4000, 16'hCAFE);
    tests_run++; if (mem_write_o !== 1'b1 || mem_wdata_o !== 16'hCAFE || mem_byte_enable_o !== 2'b11) begin fails++; $display("FAIL ww_req: got %b %h %b want 1 cafe 11", mem_write_o, mem_wdata_o, mem_byte_enable_o); end
    respond(16'h0000);
    tests_run++; if ({done_o, err_o} !== 2'b10 || rdata_o !== 16'h0022) begin fails++; $display("FAIL ww_done: got %b %h want 10 0022", {done_o, err_o}, rdata_o); end
    tick();
  endtask

  task automatic test_timeout();
    int strobes = 0;
    issue(1'b0, 1'b0, 16'h5000, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      if (mem_read_o === 1'b1 && done_o === 1'b0) strobes++;
      tick();
    end
    tests_run++; if (strobes != 4) begin fails++; $display("FAIL to_strobes: got %0d want 4", strobes); end
    tests_run++; if ({done_o, err_o, mem_read_o} !== 3'b110 || rdata_o !== 16'h0022) begin fails++; $display("FAIL to_err: got %b %h want 110 0022", {done_o, err_o, mem_read_o}, rdata_o); end
    tick();
    tests_run++; if ({req_ready_o, err_o} !== 2'b10) begin fails++; $display("FAIL to_ready: got %b want 10", {req_ready_o, err_o}); end
    issue(1'b0, 1'b0, 16'h5000, 16'h0000);
    tick();
    tick();
    tick();
    respond(16'h7777);
    tests_run++; if ({done_o, err_o} !== 2'b10 || rdata_o !== 16'h7777) begin fails++; $display("FAIL to_lastresp: got %b %h want 10 7777", {done_o, err_o}, rdata_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] done_seq;
    logic [5:0] ready_seq;
    req_i = 1'b1; req_write_i = 1'b0; req_byte_i = 1'b0; req_addr_i = 16'h6000;
    mem_resp_i = 1'b1; mem_rdata_i = 16'h0A0B;
    for (int i = 0; i < 6; i++) begin
      tick();
      done_seq[i] = done_o;
      ready_seq[i] = req_ready_o;
    end
    req_i = 1'b0; mem_resp_i = 1'b0;
    tests_run++; if (done_seq !== 6'b010010) begin fails++; $display("FAIL b2b_done: got %b want 010010", done_seq); end
    tests_run++; if (ready_seq !== 6'b100100) begin fails++; $display("FAIL b2b_ready: got %b want 100100", ready_seq); end
    tests_run++; if (rdata_o !== 16'h0A0B) begin fails++; $display("FAIL b2b_rdata: got %h want 0a0b", rdata_o); end
    tick();
  endtask

  task automatic test_reset_mid_access();
    issue(1'b0, 1'b0, 16'h7000, 16'h0000);
    tick();
    rst_n = 1'b0;
    #1;
    tests_run++; if ({mem_read_o, done_o, req_ready_o} !== 3'b001) begin fails++; $display("FAIL rm_drop: got %b want 001", {mem_read_o, done_o, req_ready_o}); end
    #3;
    rst_n = 1'b1;
    tick();
    tests_run++; if ({done_o, req_ready_o, mem_read_o} !== 3'b010) begin fails++; $display("FAIL rm_after: got %b want 010", {done_o, req_ready_o, mem_read_o}); end
  endtask

  task automatic test_misalign();
    issue(1'b0, 1'b0, 16'h0101, 16'h0000);
`ifdef MEMSEQ_ALIGN_CHECK_EN
    tests_run++; if ({done_o, err_o, mem_read_o} !== 3'b110) begin fails++; $display("FAIL ma_err: got %b want 110", {done_o, err_o, mem_read_o}); end
    tick();
    tests_run++; if (req_ready_o !== 1'b1 || rdata_o !== 16'h0000) begin fails++; $display("FAIL ma_ready: got %b %h want 1 0000", req_ready_o, rdata_o); end
`else
    tests_run++; if (mem_address_o !== 16'h0100 || mem_read_o !== 1'b1) begin fails++; $display("FAIL ma_addr: got %h %b want 0100 1", mem_address_o, mem_read_o); end
    respond(16'h4321);
    tests_run++; if ({done_o, err_o} !== 2'b10 || rdata_o !== 16'h4321) begin fails++; $display("FAIL ma_done: got %b %h want 10 4321", {done_o, err_o}, rdata_o); end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_resp_ignored();
    test_byte_write();
    test_byte_read();
    test_word_write_min_latency();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
